data_memory_unit: RTL
=====================

# data_memory_unit

Multicycle data memory for the CPU datapath, sitting directly upstream of the memory data register. Accepts one load or store request at a time through a req/busy/done handshake, models a fixed number of wait states, and supports byte, halfword and word accesses in little-endian order. Load data is sign- or zero-extended and held on `mem_data` for the next stage to capture. Misaligned, illegal-size or out-of-range accesses are rejected with an error flag.

## Interface
- `ADDR_WIDTH`, 10: byte-address width of the array; depth is 2^(ADDR_WIDTH-2) 32-bit words.
- `WAIT_STATES`, 2: wait cycles before the array access; legal range 0..15.

- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `unsigned_ld`  in  1  1 = zero-extend loads, 0 = sign-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the byte or half is taken from the low lanes.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = request rejected.
- `mem_data`  out  32  load result, held until the next load completes or is rejected.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE with `req`=1: capture `addr`, `we`, `size`, `unsigned_ld` and `wdata`.
  - The request is illegal if any of these holds:
    - `size`=11;
    - half access with `addr[0]`=1;
    - word access with `addr[1:0]`≠0;
    - `addr[31:ADDR_WIDTH]`≠0.
  - Illegal request: go to RESP with `err`=1. No array write; `mem_data` is set to 0.
  - Legal request: go to WAIT with the counter loaded to WAIT_STATES-1. If WAIT_STATES=0, go straight to ACCESS.
- WAIT: decrement the counter each cycle; go to ACCESS when it is 0.
- ACCESS:
  - One cycle. The array operation is committed at the edge that leaves ACCESS.
  - Word index is `addr[ADDR_WIDTH-1:2]`.
  - Store, byte: write only lane `addr[1:0]` with `wdata[7:0]`.
  - Store, half: write only lanes {`addr[1]`,0} and {`addr[1]`,1} with `wdata[15:0]`, low byte in the lower lane.
  - Store, word: write the full word.
  - Load: select the addressed byte or half, extend it per `unsigned_ld`, and register it into `mem_data`.
  - Next state is RESP.
- RESP:
  - `done`=1 for exactly one cycle; `err`=0 for a legal request.
  - A store leaves `mem_data` unchanged.
  - Next state is IDLE.
- `req` while `busy`=1 is ignored and is not queued.
- A new request may be accepted in the IDLE cycle immediately after RESP.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `mem_data`=0x0000_0000. Array contents are not reset.
- Let E0 be the edge that accepts a request.
  - Legal request: `done` is high in the cycle after edge E0+WAIT_STATES+1.
  - Rejected request: `done` is high in the cycle after E0.
- `busy` rises in the cycle after E0 and falls in the same cycle `done` falls.
- `mem_data` changes only at the edge entering RESP, and is stable for at least the `done` cycle.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately and no `done` pulse is produced.
  - If reset asserts before the ACCESS exit edge, the store is not committed.
- `done` and `err` are registered outputs. `busy` is decoded from the state register.

## Test plan
- Word store 0x8040_20F1 to 0x10, then word load from 0x10, WAIT_STATES=2 -> `mem_data`=0x8040_20F1, `done` 4 cycles after the accepting edge, `err`=0.
- From that word:
  - signed byte load at 0x10 -> 0xFFFF_FFF1;
  - unsigned byte load at 0x13 -> 0x0000_0080;
  - signed half load at 0x12 -> 0xFFFF_8040;
  - unsigned half load at 0x10 -> 0x0000_20F1.
- Byte store of 0x55 to 0x11, then word load from 0x10 -> 0x8040_55F1, other lanes unchanged.
- Each of the following -> `done`=1 and `err`=1 one cycle after acceptance, `mem_data`=0, and a following word load from 0x10 is unchanged:
  - half load at 0x11;
  - word store at 0x12;
  - `size`=11;
  - word load at 0x400 (ADDR_WIDTH=10).
- `req` held high continuously with changing `addr` -> only the requests sampled in IDLE execute, one `done` per transaction, no lost or duplicate accesses. Repeat with WAIT_STATES=0: `done` 2 cycles after acceptance.
- Word store of 0xDEAD_BEEF to 0x20 with `rst_n` pulsed low during WAIT -> outputs return to their reset values asynchronously and no `done` pulse appears. A later word load from 0x20 returns the value stored there before the reset.

Source files
------------

// File: rtl/data_memory_unit.sv
// Multicycle data memory: one load/store at a time via req/busy/done, fixed wait states,
// little-endian byte/half/word access with sign/zero-extended loads held on mem_data.
module data_memory_unit #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_data
);

   localparam int unsigned DEPTH     = 2 ** (ADDR_WIDTH - 2);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [3:0]              cnt;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    we_q;
   logic [1:0]              size_q;
   logic                    uns_q;
   logic [31:0]             wdata_q;

   logic                    accept;
   logic                    illegal;
   logic [ADDR_WIDTH-3:0]   word_idx;
   logic [31:0]             word_rd;
   logic [3:0]              lane_en;
   logic [31:0]             wr_word;
   logic                    wr_en;
   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;
   logic [31:0]             ld_data;

   logic [31:0]             mem [DEPTH];

   assign accept = (state == IDLE) && req;

   always_comb begin
      illegal = (size == 2'b11)
             || ((size == 2'b01) && addr[0])
             || ((size == 2'b10) && (addr[1:0] != 2'b00))
             || ((addr >> ADDR_WIDTH) != 32'd0);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (illegal) begin
                  state_next = RESP;
               end else if (WAIT_STATES == 0) begin
                  state_next = ACCESS;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT:    if (cnt == 4'd0) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy = (state != IDLE);
   end

   // Request capture, wait counter and registered responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         size_q   <= '0;
         uns_q    <= 1'b0;
         wdata_q  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         mem_data <= '0;
      end else begin
         done <= (state_next == RESP);
         err  <= accept && illegal;
         if (accept) begin
            addr_q  <= addr[ADDR_WIDTH-1:0];
            we_q    <= we;
            size_q  <= size;
            uns_q   <= unsigned_ld;
            wdata_q <= wdata;
            cnt     <= WAIT_LOAD;
            if (illegal) begin
               mem_data <= '0;
            end
         end
         if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if ((state == ACCESS) && !we_q) begin
            mem_data <= ld_data;
         end
      end
   end

   assign word_idx = addr_q[ADDR_WIDTH-1:2];
   assign word_rd  = mem[word_idx];
   assign wr_en    = (state == ACCESS) && we_q;

   // Narrow stores replicate the low lanes so the lane enables alone pick the target bytes
   always_comb begin
      case (size_q)
         2'b00: begin
            lane_en = 4'b0001 << addr_q[1:0];
            wr_word = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{wdata_q[15:0]}};
         end
         default: begin
            lane_en = 4'b1111;
            wr_word = wdata_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               mem[word_idx][i*8 +: 8] <= wr_word[i*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      case (addr_q[1:0])
         2'b00:   byte_sel = word_rd[7:0];
         2'b01:   byte_sel = word_rd[15:8];
         2'b10:   byte_sel = word_rd[23:16];
         default: byte_sel = word_rd[31:24];
      endcase
      half_sel = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
      case (size_q)
         2'b00:   ld_data = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   ld_data = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ld_data = word_rd;
      endcase
   end

endmodule
